// File: rtl/var_init_counter_bank_if.sv
// Counter bank bus: per-channel enables, load/readback controls, outputs.
// master drives controls (en/load/load_ch/load_data/rd_ch); slave drives
// rd_data, cnt_flat, wrap and the net any_wrap.
interface var_init_counter_bank_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  localparam int CW = $clog2(CHANNELS) + 1;

  logic [CHANNELS-1:0]       en;
  logic                      load;
  logic [CW-1:0]             load_ch;
  logic [WIDTH-1:0]          load_data;
  logic [CW-1:0]             rd_ch;
  logic [WIDTH-1:0]          rd_data;
  logic [CHANNELS*WIDTH-1:0] cnt_flat;
  logic [CHANNELS-1:0]       wrap;
  wire                       any_wrap;

  modport master (
    output en, load, load_ch, load_data, rd_ch,
    input  rd_data, cnt_flat, wrap, any_wrap
  );

  modport slave (
    input  en, load, load_ch, load_data, rd_ch,
    output rd_data, cnt_flat, wrap, any_wrap
  );
endinterface

// File: rtl/var_init_counter_bank.sv
// Bank of CHANNELS wrapping up/down counters with load, readback, wrap flags.
// Ports: clk, rst (sync, active-high), bus (slave side of the bank bus).
module var_init_counter_bank #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter logic [31:0] LIMIT =
    32'((64'd1 << WIDTH) - 64'd1),
  parameter int INIT_VAL = 1,
  parameter int RST_VAL  = 0,
  parameter int STORAGE  = 0,
  parameter logic [CHANNELS-1:0] COUNT_DOWN = '0
) (
  input logic clk,
  input logic rst,
  var_init_counter_bank_if.slave bus
);
  localparam int CW = $clog2(CHANNELS) + 1;
  localparam logic [WIDTH-1:0] INIT_W = WIDTH'(INIT_VAL);
  localparam logic [WIDTH-1:0] RST_W  = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] LIM_W  = LIMIT[WIDTH-1:0];

  logic [WIDTH-1:0]    cnt [CHANNELS];
  logic [CHANNELS-1:0] wrap_d;
  logic [CHANNELS-1:0] wrap_q = '0;
  logic [WIDTH-1:0]    rd_d;
  logic [WIDTH-1:0]    rd_q = '0;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic             hit;
    logic [31:0]      cur32;
    logic [WIDTH-1:0] ld_w;
    logic [WIDTH-1:0] nxt;
    logic             wrp;

    assign hit  = bus.load && (bus.load_ch == CW'(c));
    assign ld_w = (32'(bus.load_data) > LIMIT) ? LIM_W
                                               : bus.load_data;

    // Wrap is judged on the 32-bit value against LIMIT.
    always_comb begin
      nxt = cnt[c];
      wrp = 1'b0;
      if (hit) begin
        nxt = ld_w;
      end else if (bus.en[c]) begin
        if (COUNT_DOWN[c]) begin
          if (cur32 == 32'd0) begin
            nxt = LIM_W;
            wrp = 1'b1;
          end else begin
            nxt = WIDTH'(cur32 - 32'd1);
          end
        end else begin
          if (cur32 >= LIMIT) begin
            nxt = '0;
            wrp = 1'b1;
          end else begin
            nxt = WIDTH'(cur32 + 32'd1);
          end
        end
      end
    end

    assign wrap_d[c] = wrp;

    if (STORAGE == 2) begin : g_int
      integer q = 32'(INIT_W);
      always_ff @(posedge clk) begin
        if (rst) q <= 32'(RST_W);
        else     q <= 32'(nxt);
      end
      assign cur32  = q;
      assign cnt[c] = q[WIDTH-1:0];
    end else if (STORAGE == 1) begin : g_reg
      reg [WIDTH-1:0] q = INIT_W;
      always_ff @(posedge clk) begin
        if (rst) q <= RST_W;
        else     q <= nxt;
      end
      assign cur32  = 32'(q);
      assign cnt[c] = q;
    end else begin : g_var
      logic [WIDTH-1:0] q = INIT_W;
      always_ff @(posedge clk) begin
        if (rst) q <= RST_W;
        else     q <= nxt;
      end
      assign cur32  = 32'(q);
      assign cnt[c] = q;
    end
  end

  // Out-of-range select falls through to zero.
  always_comb begin
    rd_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (bus.rd_ch == CW'(i)) rd_d = cnt[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_q <= '0;
      rd_q   <= '0;
    end else begin
      wrap_q <= wrap_d;
      rd_q   <= rd_d;
    end
  end

  always_comb begin
    bus.cnt_flat = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      bus.cnt_flat[i*WIDTH +: WIDTH] = cnt[i];
    end
  end

  assign bus.wrap     = wrap_q;
  assign bus.rd_data  = rd_q;
  assign bus.any_wrap = |wrap_q;
endmodule

// File: tb/tb_var_init_counter_bank.sv
// Directed bench: three default banks (one per storage kind) share stimulus;
// a fourth bank (WIDTH=4, LIMIT=9, ch1 down-counting) gets its own steps.
module tb_var_init_counter_bank;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] en;
  logic       load;
  logic [2:0] load_ch;
  logic [7:0] load_data;
  logic [2:0] rd_ch;
  logic [3:0] en3;
  logic       load3;
  logic [2:0] lch3;
  logic [3:0] ld3;
  logic [2:0] rd3;
  int checks = 0;
  int errors = 0;
  int wc = 0;

  always #5 clk = ~clk;

  for (genvar s = 0; s < 3; s++) begin : g_s
    var_init_counter_bank_if #(.WIDTH(8), .CHANNELS(4)) bi ();
    assign bi.en        = en;
    assign bi.load      = load;
    assign bi.load_ch   = load_ch;
    assign bi.load_data = load_data;
    assign bi.rd_ch     = rd_ch;
    var_init_counter_bank #(.STORAGE(s)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bi.slave)
    );
  end

  var_init_counter_bank_if #(.WIDTH(4), .CHANNELS(4)) b3 ();
  assign b3.en        = en3;
  assign b3.load      = load3;
  assign b3.load_ch   = lch3;
  assign b3.load_data = ld3;
  assign b3.rd_ch     = rd3;
  var_init_counter_bank #(
    .WIDTH(4), .CHANNELS(4), .LIMIT(32'd9),
    .STORAGE(2), .COUNT_DOWN(4'b0010)
  ) u_small (
    .clk (clk),
    .rst (rst),
    .bus (b3.slave)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkall(input string tag,
                        input logic [31:0] flat,
                        input logic [3:0] wr);
    chk({tag, "_flat0"}, 64'(g_s[0].bi.cnt_flat), 64'(flat));
    chk({tag, "_flat1"}, 64'(g_s[1].bi.cnt_flat), 64'(flat));
    chk({tag, "_flat2"}, 64'(g_s[2].bi.cnt_flat), 64'(flat));
    chk({tag, "_wrap0"}, 64'(g_s[0].bi.wrap), 64'(wr));
    chk({tag, "_wrap1"}, 64'(g_s[1].bi.wrap), 64'(wr));
    chk({tag, "_wrap2"}, 64'(g_s[2].bi.wrap), 64'(wr));
    chk({tag, "_any0"}, 64'(g_s[0].bi.any_wrap), 64'(|wr));
    chk({tag, "_any2"}, 64'(g_s[2].bi.any_wrap), 64'(|wr));
  endtask

  task automatic chkrd(input string tag, input logic [7:0] exp);
    chk({tag, "_rd0"}, 64'(g_s[0].bi.rd_data), 64'(exp));
    chk({tag, "_rd1"}, 64'(g_s[1].bi.rd_data), 64'(exp));
    chk({tag, "_rd2"}, 64'(g_s[2].bi.rd_data), 64'(exp));
  endtask

  task automatic chk3(input string tag,
                      input logic [15:0] flat,
                      input logic [3:0] wr);
    chk({tag, "_flat3"}, 64'(b3.cnt_flat), 64'(flat));
    chk({tag, "_wrap3"}, 64'(b3.wrap), 64'(wr));
    chk({tag, "_any3"}, 64'(b3.any_wrap), 64'(|wr));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 0; en = 0; load = 0; load_ch = 0;
    load_data = 0; rd_ch = 0;
    en3 = 0; load3 = 0; lch3 = 0; ld3 = 0; rd3 = 0;
    #1;
    chkall("por", 32'h01010101, 4'b0000);
    chkrd("por", 8'h00);
    chk3("por", 16'h1111, 4'b0000);

    rst = 1;
    tick();
    chkall("rst", 32'h0, 4'b0000);
    chkrd("rst", 8'h00);
    chk3("rst", 16'h0000, 4'b0000);

    rst = 0; en = 4'b0001;
    for (int i = 0; i < 255; i++) begin
      tick();
      if (g_s[0].bi.wrap[0]) wc++;
    end
    chkall("c255", 32'h000000FF, 4'b0000);
    chkrd("c255", 8'hFE);
    tick();
    if (g_s[0].bi.wrap[0]) wc++;
    chkall("wrap", 32'h0, 4'b0001);
    en = 4'b0000;
    tick();
    if (g_s[0].bi.wrap[0]) wc++;
    chkall("post", 32'h0, 4'b0000);
    chk("wrapcnt", 64'(wc), 64'd1);

    load = 1; load_ch = 0; load_data = 8'hFF;
    tick();
    chkall("ldff", 32'h000000FF, 4'b0000);
    en = 4'b0001; load_data = 8'h05;
    tick();
    chkall("ldwin", 32'h00000005, 4'b0000);
    en = 4'b0000; load_ch = 7; load_data = 8'hAA;
    tick();
    chkall("ldoor", 32'h00000005, 4'b0000);
    load_ch = 2; load_data = 8'h33;
    tick();
    chkall("ld2", 32'h00330005, 4'b0000);

    load = 0; rd_ch = 2;
    tick();
    chkrd("rd2", 8'h33);
    rd_ch = 6;
    tick();
    chkrd("rd6", 8'h00);
    rd_ch = 0;
    tick();
    chkrd("rd0", 8'h05);

    load = 1; load_ch = 3; load_data = 8'hFE;
    tick();
    chkall("ld3", 32'hFE330005, 4'b0000);
    load_ch = 0; load_data = 8'h63;
    tick();
    chkall("ld63", 32'hFE330063, 4'b0000);
    load = 0; en = 4'b1001;
    tick();
    chkall("c100", 32'hFF330064, 4'b0000);
    rd_ch = 2; load = 1; load_ch = 1; load_data = 8'h07;
    rst = 1;
    tick();
    chkall("midrst", 32'h0, 4'b0000);
    chkrd("midrst", 8'h00);
    rst = 0; load = 0; en = 4'b0001;
    tick();
    chkall("rel", 32'h00000001, 4'b0000);
    chkrd("rel", 8'h00);
    en = 4'b0000;

    en3 = 4'b0010;
    tick();
    chk3("dn", 16'h0090, 4'b0010);
    en3 = 4'b0000; load3 = 1; lch3 = 0; ld3 = 4'd9;
    tick();
    chk3("ld9", 16'h0099, 4'b0000);
    load3 = 0; en3 = 4'b0001;
    tick();
    chk3("up9", 16'h0090, 4'b0001);
    en3 = 4'b0000; load3 = 1; lch3 = 2; ld3 = 4'd12;
    rd3 = 1;
    tick();
    chk3("clamp", 16'h0990, 4'b0000);
    chk("rd3", 64'(b3.rd_data), 64'd9);
    load3 = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
